// File: rtl/i2c_pkg.sv
// Shared types for the byte-level I2C bus master: command opcodes, FSM states, bit quarters.
package i2c_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } i2c_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP
  } i2c_state_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } i2c_qtr_e;

  // Quarter in which SCL has just been released, so a target may be stretching it.
  function automatic logic is_release_qtr(input i2c_state_e s, input i2c_qtr_e q);
    return ((s == ST_BIT) && (q == Q2)) ||
           (((s == ST_START) || (s == ST_STOP)) && (q == Q1));
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for an asynchronous bus line; resets to the idle (released) level.
module i2c_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_controller.sv
// Byte-level I2C bus master: START/WRITE/READ/STOP primitives with open-drain SDA/SCL
// generation, quarter-period bit timing and clock-stretch support.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       bus_owned,
  input  logic       sda_i,
  input  logic       scl_i,
  output logic       sda_oe,
  output logic       scl_oe
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_FULL   = QW'(CLK_DIV - 1);
  // The cycle that observes SCL high already counts toward the resumed quarter.
  localparam logic [QW-1:0] Q_RESUME = QW'(CLK_DIV - 2);

  i2c_state_e     state;
  i2c_qtr_e       qtr;
  logic [QW-1:0]  qcnt;
  logic [3:0]     bit_cnt;
  logic           is_rd;
  logic           nack_cmd;
  logic           stall;
  logic [7:0]     shreg;
  logic           sda_s;
  logic           scl_s;
  logic           rel_q;
  i2c_op_e        op;

  i2c_sync2 u_sync_sda (.clk(clk), .rst(rst), .d(sda_i), .q(sda_s));
  i2c_sync2 u_sync_scl (.clk(clk), .rst(rst), .d(scl_i), .q(scl_s));

  assign op    = i2c_op_e'(cmd_op);
  assign rel_q = is_release_qtr(state, qtr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      qtr       <= Q0;
      qcnt      <= '0;
      bit_cnt   <= '0;
      is_rd     <= 1'b0;
      nack_cmd  <= 1'b0;
      stall     <= 1'b0;
      shreg     <= '0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_nack  <= 1'b0;
      rsp_err   <= 1'b0;
      bus_owned <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            qtr       <= Q0;
            qcnt      <= Q_FULL;
            stall     <= 1'b0;
            unique case (op)
              OP_START: begin
                state  <= ST_START;
                sda_oe <= 1'b0;
              end
              OP_WRITE, OP_READ: begin
                if (!bus_owned) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end else begin
                  state    <= ST_BIT;
                  bit_cnt  <= '0;
                  is_rd    <= (op == OP_READ);
                  nack_cmd <= cmd_nack;
                  shreg    <= cmd_data;
                  scl_oe   <= 1'b1;
                  sda_oe   <= (op == OP_WRITE) && !cmd_data[7];
                end
              end
              OP_STOP: begin
                if (bus_owned) begin
                  state  <= ST_STOP;
                  scl_oe <= 1'b1;
                  sda_oe <= 1'b1;
                end
              end
            endcase
          end
        end

        default: begin
          if (qcnt != '0) begin
            qcnt <= qcnt - QW'(1);
          end else if (rel_q && !scl_s) begin
            stall <= 1'b1;
          end else if (rel_q && stall) begin
            stall <= 1'b0;
            qcnt  <= Q_RESUME;
          end else begin
            qcnt <= Q_FULL;
            qtr  <= i2c_qtr_e'(qtr + 2'd1);
            // Actions taken as the current quarter ends, setting up the next one.
            case (state)
              ST_START: begin
                unique case (qtr)
                  Q0: scl_oe <= 1'b0;
                  Q1: sda_oe <= 1'b1;
                  Q2: scl_oe <= 1'b1;
                  Q3: begin
                    bus_owned <= 1'b1;
                    state     <= ST_IDLE;
                  end
                endcase
              end
              ST_STOP: begin
                unique case (qtr)
                  Q0: scl_oe <= 1'b0;
                  Q1: ;
                  Q2: sda_oe <= 1'b0;
                  Q3: begin
                    bus_owned <= 1'b0;
                    state     <= ST_IDLE;
                  end
                endcase
              end
              default: begin
                unique case (qtr)
                  Q0: ;
                  Q1: scl_oe <= 1'b0;
                  Q2: ;
                  Q3: begin
                    scl_oe <= 1'b1;
                    if (bit_cnt == 4'd8) begin
                      rsp_valid <= 1'b1;
                      rsp_data  <= shreg;
                      rsp_nack  <= sda_s;
                      rsp_err   <= 1'b0;
                      state     <= ST_IDLE;
                    end else begin
                      shreg   <= {shreg[6:0], sda_s};
                      bit_cnt <= bit_cnt + 4'd1;
                      if (bit_cnt == 4'd7)
                        sda_oe <= is_rd && !nack_cmd;
                      else
                        sda_oe <= !is_rd && !shreg[6];
                    end
                  end
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Scoreboarded bench for i2c_controller: open-drain bus with a behavioural target.
module tb_i2c_controller;

  localparam int CD     = 4;
  localparam int T_BYTE = 36 * CD;
  localparam int HOLD   = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_nack = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, bus_owned, sda_oe, scl_oe;
  logic [7:0] rsp_data;
  logic       tgt_sda_low = 1'b0;
  logic       tgt_scl_low = 1'b0;
  logic       sda_line, scl_line;

  assign sda_line = !(sda_oe || tgt_sda_low);
  assign scl_line = !(scl_oe || tgt_scl_low);

  always #5 clk = ~clk;

  i2c_controller #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack), .rsp_err(rsp_err),
    .bus_owned(bus_owned),
    .sda_i(sda_line), .scl_i(scl_line), .sda_oe(sda_oe), .scl_oe(scl_oe)
  );

  typedef struct {
    logic [7:0] data;
    logic       nack;
    logic       err;
    int         lat;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e_r;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0;
  int   sda_fall_hi = 0, sda_rise_hi = 0, scl_edges = 0;
  logic sda_d = 1'b1, scl_d = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc + 1;
  end

  // Bus edge monitor and response scoreboard.
  always @(negedge clk) begin
    if (scl_line != scl_d) scl_edges++;
    if (scl_line && scl_d && (sda_line != sda_d)) begin
      if (sda_line) sda_rise_hi++;
      else sda_fall_hi++;
    end
    sda_d = sda_line;
    scl_d = scl_line;
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(exp_q.size()), 1);
      end else begin
        e_r = exp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e_r.err));
        if (!e_r.err) begin
          chk("rsp_data", 32'(rsp_data), 32'(e_r.data));
          chk("rsp_nack", 32'(rsp_nack), 32'(e_r.nack));
        end
        chk("rsp_lat", cyc - acc_cyc, e_r.lat);
      end
    end
  end

  task automatic wait_scl(input logic lvl);
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = (scl_line == lvl);
    end
    if (!ok) chk("scl_timeout", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk("idle_timeout", 32'(ok), 1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic nk);
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk("rdy_timeout", 32'(ok), 1);
    cmd_op = op; cmd_data = d; cmd_nack = nk; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rdy_drop", 32'(cmd_ready), 0);
  endtask

  task automatic tgt_write(input logic ack, output logic [7:0] got);
    got = 8'd0;
    for (int i = 0; i < 8; i++) begin
      wait_scl(1'b1);
      got = {got[6:0], sda_line};
      wait_scl(1'b0);
    end
    tgt_sda_low = ack;
    wait_scl(1'b1);
    wait_scl(1'b0);
    tgt_sda_low = 1'b0;
  endtask

  task automatic tgt_read(input logic [7:0] b, output logic mack);
    logic [7:0] sh;
    sh = b;
    tgt_sda_low = !sh[7];
    for (int i = 0; i < 8; i++) begin
      wait_scl(1'b1);
      wait_scl(1'b0);
      sh = sh << 1;
      tgt_sda_low = (i < 7) ? !sh[7] : 1'b0;
    end
    wait_scl(1'b1);
    mack = sda_line;
    wait_scl(1'b0);
  endtask

  task automatic stretch(input int nbit, input int hold);
    bit ok = 1'b0;
    for (int i = 0; i < nbit; i++) begin
      wait_scl(1'b1);
      wait_scl(1'b0);
    end
    tgt_scl_low = 1'b1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = !scl_oe;
    end
    if (!ok) chk("stretch_timeout", 32'(ok), 1);
    repeat (hold) @(negedge clk);
    tgt_scl_low = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic       mack;
    int         f0, r0, e0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_scl_oe", 32'(scl_oe), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_nack", 32'(rsp_nack), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_bus_owned", 32'(bus_owned), 0);

    issue(2'd0, 8'h00, 1'b0);
    wait_idle();
    chk("start_owned", 32'(bus_owned), 1);

    exp_q.push_back('{data: 8'h5A, nack: 1'b0, err: 1'b0, lat: T_BYTE});
    fork
      issue(2'd1, 8'h5A, 1'b0);
      tgt_write(1'b1, got);
    join
    wait_idle();
    chk("wr5a_bus_bits", 32'(got), 'h5A);

    exp_q.push_back('{data: 8'h3C, nack: 1'b1, err: 1'b0, lat: T_BYTE});
    fork
      issue(2'd1, 8'h3C, 1'b0);
      tgt_write(1'b0, got);
    join
    wait_idle();
    chk("wr3c_bus_bits", 32'(got), 'h3C);

    exp_q.push_back('{data: 8'h3E, nack: 1'b0, err: 1'b0, lat: T_BYTE});
    fork
      issue(2'd2, 8'h00, 1'b0);
      tgt_read(8'h3E, mack);
    join
    wait_idle();
    chk("rd3e_master_ack", 32'(mack), 0);

    exp_q.push_back('{data: 8'hA5, nack: 1'b1, err: 1'b0, lat: T_BYTE});
    fork
      issue(2'd2, 8'h00, 1'b1);
      tgt_read(8'hA5, mack);
    join
    wait_idle();
    chk("rda5_master_nack", 32'(mack), 1);

    exp_q.push_back('{data: 8'h96, nack: 1'b0, err: 1'b0, lat: T_BYTE + HOLD + 2});
    fork
      issue(2'd1, 8'h96, 1'b0);
      tgt_write(1'b1, got);
      stretch(3, HOLD);
    join
    wait_idle();
    chk("stretch_bus_bits", 32'(got), 'h96);

    issue(2'd3, 8'h00, 1'b0);
    wait_idle();
    chk("stop_owned", 32'(bus_owned), 0);

    f0 = sda_fall_hi;
    r0 = sda_rise_hi;
    issue(2'd0, 8'h00, 1'b0);
    wait_idle();
    chk("seq_owned_start", 32'(bus_owned), 1);
    exp_q.push_back('{data: 8'hB0, nack: 1'b0, err: 1'b0, lat: T_BYTE});
    fork
      issue(2'd1, 8'hB0, 1'b0);
      tgt_write(1'b1, got);
    join
    wait_idle();
    chk("seq_wr_bits", 32'(got), 'hB0);
    chk("seq_owned_wr", 32'(bus_owned), 1);
    issue(2'd0, 8'h00, 1'b0);
    wait_idle();
    chk("seq_owned_rstart", 32'(bus_owned), 1);
    exp_q.push_back('{data: 8'h81, nack: 1'b1, err: 1'b0, lat: T_BYTE});
    fork
      issue(2'd2, 8'h00, 1'b1);
      tgt_read(8'h81, mack);
    join
    wait_idle();
    chk("seq_owned_rd", 32'(bus_owned), 1);
    issue(2'd3, 8'h00, 1'b0);
    wait_idle();
    chk("seq_owned_stop", 32'(bus_owned), 0);
    repeat (2) @(negedge clk);
    chk("seq_sda_fall_hi", sda_fall_hi - f0, 2);
    chk("seq_sda_rise_hi", sda_rise_hi - r0, 1);

    e0 = scl_edges;
    exp_q.push_back('{data: 8'h00, nack: 1'b0, err: 1'b1, lat: 0});
    issue(2'd1, 8'h11, 1'b0);
    wait_idle();
    issue(2'd3, 8'h00, 1'b0);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("err_scl_edges", scl_edges - e0, 0);
    chk("noop_stop_owned", 32'(bus_owned), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    issue(2'd0, 8'h00, 1'b0);
    wait_idle();
    issue(2'd1, 8'h77, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_scl(1'b1);
      wait_scl(1'b0);
    end
    repeat (2) @(negedge clk);
    chk("pre_rst_sda_oe", 32'(sda_oe), 1);
    chk("pre_rst_scl_oe", 32'(scl_oe), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sda_oe", 32'(sda_oe), 0);
    chk("mid_rst_scl_oe", 32'(scl_oe), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("post_rst_owned", 32'(bus_owned), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_controller.md
# i2c_controller

Byte-level I2C controller (bus master) that drives the open-drain SDA/SCL pair from the initiating end of the bus the SIMON I2C target sits on. A command interface issues START, WRITE, READ and STOP primitives, and the block generates all bus timing. It is the on-chip and bench-side counterpart for exercising the target over real bus waveforms, including clock stretching.

## Interface
- `CLK_DIV`, default 25: clk cycles per SCL quarter-period; SCL = f_clk/(4·CLK_DIV). Minimum 4.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE; transfer on `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 0=START, 1=WRITE, 2=READ, 3=STOP.
- `cmd_data` in 8: byte for WRITE.
- `cmd_nack` in 1: for READ, 1 = send NACK (last byte), 0 = send ACK.
- `rsp_valid` out 1: one-cycle pulse at completion of WRITE/READ.
- `rsp_data` out 8: READ = received byte; WRITE = byte sampled back from bus.
- `rsp_nack` out 1: ACK-bit level sampled (WRITE: target ACK; READ: echoes level driven).
- `rsp_err` out 1: WRITE/READ issued while bus not owned.
- `bus_owned` out 1: set after START completes, cleared after STOP completes.
- `sda_i`, `scl_i` in 1 each: bus levels.
- `sda_oe`, `scl_oe` out 1 each: 1 = pull line low, 0 = release.

## Operation
- `sda_i`/`scl_i` pass through 2-flop synchronizers; all decisions use synchronized values.
- Quarter counter counts `CLK_DIV`-1..0; each bus bit is 4 quarters Q0..Q3.
- FSM states: IDLE, START, BIT, STOP. Bit counter 0..8 (8 = ACK slot).
- START (also repeated start): Q0 release SDA, SCL unchanged; Q1 release SCL; Q2 pull SDA low; Q3 pull SCL low. Sets `bus_owned`.
- BIT: Q0 SCL low, set SDA (WRITE: MSB first, then release for ACK; READ: release, then drive `cmd_nack` on bit 8); Q1 hold; Q2 release SCL; Q3 SCL high, sample `sda_i` at end of Q3 into shift register / ack flag. After bit 8 Q3: pull SCL low, pulse `rsp_valid`, return to IDLE.
- STOP: Q0 SCL low, SDA low; Q1 release SCL; Q2 hold; Q3 release SDA. Clears `bus_owned`.
- Clock stretching: the quarter counter does not advance after the SCL release (Q1 of START/STOP, Q2 of BIT) until synchronized `scl_i` reads 1; the full quarter then runs from that point. No timeout.
- WRITE/READ with `bus_owned`=0: accepted, no bus activity, `rsp_valid` with `rsp_err`=1 on the next cycle. STOP with `bus_owned`=0: accepted, no-op, no response.
- No arbitration-loss detection; `rsp_data` on WRITE allows software to compare.

## Timing
- Reset values: `sda_oe`=0, `scl_oe`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_nack`=0, `rsp_err`=0, `bus_owned`=0, FSM IDLE. Reset mid-transfer releases both lines immediately (possible bus glitch is accepted).
- `cmd_ready` drops the cycle after acceptance.
- Unstretched latency: START and STOP take 4·CLK_DIV cycles; WRITE/READ take 36·CLK_DIV cycles from acceptance to `rsp_valid`. `cmd_ready` rises the cycle after `rsp_valid` or after the final quarter.
- Stretching adds (stretch duration + 2 synchronizer cycles).
- SDA changes only in Q0 while SCL is low, except SDA edges in START/STOP Q2/Q3.
- Response fields hold until the next response.

## Structure
- Package `i2c_pkg`: `cmd_op` enum (START/WRITE/READ/STOP), FSM state enum, quarter enum.
- Sub-module `i2c_sync2`: 2-flop synchronizer, instantiated for SDA and SCL.
- Everything else lives in `i2c_controller`. Target: about 200 lines of RTL.

## Test plan
- Use open-drain bench wiring (line = 0 if any side pulls low), CLK_DIV=4.
- START, WRITE 0x5A, target ACKs: SDA on SCL rising edges = 0,1,0,1,1,0,1,0. Expect `rsp_valid` with `rsp_data`=0x5A, `rsp_nack`=0, `rsp_err`=0, 144 cycles after acceptance.
- WRITE 0x3C with no target: `rsp_nack`=1.
- READ, target drives 0xA5, `cmd_nack`=1: `rsp_data`=0xA5, `rsp_nack`=1, SDA released in bit 8.
- Target holds SCL low 100 cycles at a BIT Q2: SCL high period is 4 cycles after release; total latency grows by 102 cycles.
- START, WRITE 0xB0, START, READ, STOP: SDA falls with SCL high twice and rises with SCL high once. `bus_owned` follows 1…1 then 0. A subsequent WRITE gives `rsp_err`=1 and no SCL edges.
- Assert `rst` at bit 4 of a WRITE: `sda_oe`=`scl_oe`=0 in the same cycle; after release, `cmd_ready`=1 and `bus_owned`=0.
